fpu_op_sequencer: RTL
=====================

// Module: fpu_op_sequencer
// PURPOSE
//  Issues FP arithmetic ops from the decoder to the multi-cycle FPU datapath, tracks the single
//  in-flight op, and writes its result to the FP register file. Shares that write port with
//  direct CPU writes (mtc1/lwc1); the CPU has priority. Exports the pending destination so the
//  CPU can detect RAW hazards. Sits between the op decoder, the FPU core and the FP regfile.
// PARAMETERS
//  DATA_W   32  operand/result width
//  ADD_LAT   3  cycles from fpu_start to valid fpu_result, add/sub
//  MUL_LAT   4  same, mul
//  DIV_LAT  16  same, div (every LAT >= 1)
// PORTS
//  clk           in   1       clock, rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  issue_valid   in   1       decoder presents an FP op
//  issue_ready   out  1       sequencer can accept an op
//  issue_op      in   3       000 add, 001 sub, 010 mul, 011 div, others illegal
//  issue_a       in   DATA_W  operand A (fs data)
//  issue_b       in   DATA_W  operand B (ft data)
//  issue_fd      in   5       destination FP register
//  flush         in   1       synchronous abort of in-flight op
//  fpu_start     out  1       one-cycle start strobe to FPU core
//  fpu_op        out  2       op to FPU core, held from start until result capture
//  fpu_a/fpu_b   out  DATA_W  latched operands, held likewise
//  fpu_result    in   DATA_W  FPU core result
//  cpu_fp_we     in   1       CPU write to FP regfile this cycle
//  cpu_fp_waddr  in   5       CPU write address
//  fp_we         out  1       sequencer write enable to FP regfile
//  fp_waddr      out  5       = latched fd
//  fp_wdata      out  DATA_W  = captured result
//  pend_valid    out  1       op in EXEC or WB and not killed
//  pend_fd       out  5       destination of pending op
//  illegal_op    out  1       one-cycle pulse on illegal op accept
//  op_count      out  16      ops whose result was written; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except issue_ready=1; latches, counter, kill cleared.
//  FSM IDLE/EXEC/WB. issue_ready = (state==IDLE). Handshake = issue_valid & issue_ready at edge.
//  IDLE, legal op accepted at edge T: latch op/a/b/fd, load cnt=LAT(op), ->EXEC.
//   fpu_start=1 for exactly the first EXEC cycle (T+1), registered.
//  IDLE, illegal op: accepted, illegal_op=1 in cycle T+1, no fpu_start, stay IDLE.
//  EXEC: cnt decrements each cycle after start cycle; at edge ending cycle T+1+LAT capture
//   fpu_result, ->WB.
//  WB: fp_we = ~cpu_fp_we & ~kill & ~flush (combinational). On write edge: op_count++, ->IDLE.
//   If cpu_fp_we=1, hold WB (retry next cycle). If kill=1: no write, no count, ->IDLE next edge.
//  Min issue->write: write in cycle T+2+LAT; issue_ready high in T+3+LAT.
//  WAW kill: in EXEC or WB, cpu_fp_we & cpu_fp_waddr==pend_fd sets kill (CPU write is
//   program-later); pend_valid drops the next cycle. fd=0 is an ordinary register.
//  flush in EXEC/WB: ->IDLE next edge, no write, fpu_start not re-pulsed; flush in IDLE ignored
//   (handshake in same cycle still accepted). flush in cycle of fpu_start: FPU result ignored.
//  pend_valid/pend_fd valid from cycle T+1 until the write/kill/flush edge.
//  reset_n low mid-op: immediate abort, no write, reset values.
// TESTING
//  add, a=3F800000 b=40000000 fd=4, port free -> fpu_start in T+1, fp_we T+5, waddr 4,
//   wdata = FPU result, op_count=1.
//  div with cpu_fp_we=1 (addr 7) for 3 cycles over WB, fd=4 -> fp_we delayed 3 cycles, one write.
//  mul fd=9, CPU writes reg 9 during EXEC -> no fp_we, pend_valid falls, op_count unchanged.
//  issue_op=111 -> illegal_op pulse, no fpu_start, issue_ready stays 1.
//  flush two cycles into DIV -> IDLE next cycle, no write; next add completes normally.
//  reset_n low mid-EXEC then high -> all outputs at reset values, issue_ready=1.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Issues one FP op at a time to the multi-cycle FPU core and retires its result through the
// FP register-file write port, which it shares with (and yields to) direct CPU writes.
module fpu_op_sequencer #(
   parameter int DATA_W  = 32,
   parameter int ADD_LAT = 3,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        issue_op,
   input  logic [DATA_W-1:0] issue_a,
   input  logic [DATA_W-1:0] issue_b,
   input  logic [4:0]        issue_fd,
   input  logic              flush,
   output logic              fpu_start,
   output logic [1:0]        fpu_op,
   output logic [DATA_W-1:0] fpu_a,
   output logic [DATA_W-1:0] fpu_b,
   input  logic [DATA_W-1:0] fpu_result,
   input  logic              cpu_fp_we,
   input  logic [4:0]        cpu_fp_waddr,
   output logic              fp_we,
   output logic [4:0]        fp_waddr,
   output logic [DATA_W-1:0] fp_wdata,
   output logic              pend_valid,
   output logic [4:0]        pend_fd,
   output logic              illegal_op,
   output logic [15:0]       op_count
);

   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? ((DIV_LAT > ADD_LAT) ? DIV_LAT : ADD_LAT)
                                                : ((MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT);
   localparam int CNT_W = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t              state, next_state;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    lat_sel;
   logic [4:0]          fd_q;
   logic [DATA_W-1:0]   result_q;
   logic                kill;
   logic                accept;
   logic                legal;
   logic                busy;

   assign issue_ready = (state == IDLE);
   assign accept      = issue_valid & issue_ready;
   assign legal       = ~issue_op[2];
   assign busy        = (state == EXEC) || (state == WB);
   assign pend_valid  = busy & ~kill;
   assign pend_fd     = fd_q;
   assign fp_waddr    = fd_q;
   assign fp_wdata    = result_q;

   // Latency of the op being accepted; add and sub share the adder path.
   always_comb begin
      lat_sel = CNT_W'(ADD_LAT);
      case (issue_op[1:0])
         2'b10:   lat_sel = CNT_W'(MUL_LAT);
         2'b11:   lat_sel = CNT_W'(DIV_LAT);
         default: lat_sel = CNT_W'(ADD_LAT);
      endcase
   end

   // Next state and the write strobe; the CPU always wins the regfile port, so WB just waits.
   always_comb begin
      next_state = state;
      fp_we      = 1'b0;
      case (state)
         IDLE: if (accept && legal) next_state = EXEC;
         EXEC: begin
            if (flush)            next_state = IDLE;
            else if (cnt == '0)   next_state = WB;
         end
         WB: begin
            if (flush || kill)    next_state = IDLE;
            else if (!cpu_fp_we) begin
               fp_we      = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Operand latches, latency counter and result capture; cnt reaches zero in the capture cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fpu_start  <= 1'b0;
         illegal_op <= 1'b0;
         fpu_op     <= '0;
         fpu_a      <= '0;
         fpu_b      <= '0;
         fd_q       <= '0;
         cnt        <= '0;
         result_q   <= '0;
      end else begin
         fpu_start  <= accept & legal;
         illegal_op <= accept & ~legal;
         if (accept && legal) begin
            fpu_op <= issue_op[1:0];
            fpu_a  <= issue_a;
            fpu_b  <= issue_b;
            fd_q   <= issue_fd;
            cnt    <= lat_sel;
         end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (state == EXEC && cnt == '0 && !flush)
            result_q <= fpu_result;
      end
   end

   // A later CPU write to our destination makes our result stale (WAW), so the op is killed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kill     <= 1'b0;
         op_count <= '0;
      end else begin
         if (accept && legal)
            kill <= 1'b0;
         else if (busy && next_state == IDLE)
            kill <= 1'b0;
         else if (busy && cpu_fp_we && cpu_fp_waddr == fd_q)
            kill <= 1'b1;
         if (fp_we)
            op_count <= op_count + 16'd1;
      end
   end

endmodule
